// File: rtl/de_pipeline_ctrl.sv
// Hazard/sequencing controller for the decode/execute pipeline register.
// Optional load-use interlock is compiled in with `define LOAD_USE_STALL_EN.
module de_pipeline_ctrl #(
    parameter int BRANCH_PENALTY = 2,
    parameter int INT_CYCLES     = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [2:0] d_src1_i,
    input  logic [2:0] d_src2_i,
    input  logic       d_use1_i,
    input  logic       d_use2_i,
    input  logic       de_mr_i,
    input  logic       de_rw_i,
    input  logic [2:0] de_reg_dst_i,
    input  logic       ex_branch_taken_i,
    input  logic       int_req_i,
    input  logic       mem_busy_i,
    output logic       pc_write_o,
    output logic       fd_write_o,
    output logic       fd_flush_o,
    output logic       de_hold_o,
    output logic       de_flush_o,
    output logic [1:0] flash_num_o,
    output logic       int_ack_o,
    output logic [1:0] int_phase_o
);

    typedef enum logic [2:0] {RUN, STALL, FLUSH, INT, MEMWAIT} state_t;

    localparam logic [1:0] BP_M1    = 2'(BRANCH_PENALTY - 1);
    localparam logic [1:0] BP_M2    = 2'(BRANCH_PENALTY - 2);
    localparam logic [1:0] INT_LAST = 2'(INT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       load_use;

`ifdef LOAD_USE_STALL_EN
    assign load_use = de_mr_i & de_rw_i &
                      ((d_use1_i & (d_src1_i == de_reg_dst_i)) |
                       (d_use2_i & (d_src2_i == de_reg_dst_i)));
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{d_src1_i, d_src2_i, d_use1_i, d_use2_i,
                                    de_mr_i, de_rw_i, de_reg_dst_i};
    assign load_use = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic       pc_w, fd_w, fd_f, hold, de_f, ack;
    logic [1:0] fnum, phase;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_w    = 1'b0;
        fd_w    = 1'b0;
        fd_f    = 1'b0;
        hold    = 1'b0;
        de_f    = 1'b0;
        ack     = 1'b0;
        fnum    = 2'd0;
        phase   = 2'd0;
        unique case (state_q)
            RUN: begin
                if (mem_busy_i) begin
                    hold    = 1'b1;
                    state_d = MEMWAIT;
                end else if (ex_branch_taken_i) begin
                    pc_w = 1'b1;
                    fd_w = 1'b1;
                    fd_f = 1'b1;
                    de_f = 1'b1;
                    fnum = BP_M1;
                    if (BRANCH_PENALTY > 1) begin
                        state_d = FLUSH;
                        cnt_d   = BP_M2;
                    end
                end else if (load_use) begin
                    de_f    = 1'b1;
                    state_d = STALL;
                end else if (int_req_i) begin
                    de_f    = 1'b1;
                    state_d = INT;
                    cnt_d   = 2'd0;
                end else begin
                    pc_w = 1'b1;
                    fd_w = 1'b1;
                end
            end
            STALL: begin
                pc_w    = 1'b1;
                fd_w    = 1'b1;
                state_d = RUN;
            end
            FLUSH: begin
                // A busy memory stage freezes the squash sequence in place.
                if (mem_busy_i) begin
                    hold = 1'b1;
                end else begin
                    pc_w = 1'b1;
                    fd_w = 1'b1;
                    fd_f = 1'b1;
                    de_f = 1'b1;
                    fnum = cnt_q;
                    if (cnt_q == 2'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 2'd1;
                end
            end
            INT: begin
                de_f  = 1'b1;
                phase = cnt_q;
                if (cnt_q == INT_LAST) begin
                    ack     = 1'b1;
                    pc_w    = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            MEMWAIT: begin
                if (mem_busy_i) begin
                    hold = 1'b1;
                end else begin
                    pc_w    = 1'b1;
                    fd_w    = 1'b1;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Reset forces a safe bubble asynchronously, independent of the state register.
    always_comb begin
        if (!rst_n_i) begin
            pc_write_o  = 1'b0;
            fd_write_o  = 1'b0;
            fd_flush_o  = 1'b1;
            de_hold_o   = 1'b0;
            de_flush_o  = 1'b1;
            flash_num_o = 2'd0;
            int_ack_o   = 1'b0;
            int_phase_o = 2'd0;
        end else begin
            pc_write_o  = pc_w;
            fd_write_o  = fd_w;
            fd_flush_o  = fd_f;
            de_hold_o   = hold;
            de_flush_o  = de_f & ~hold;
            flash_num_o = fnum;
            int_ack_o   = ack;
            int_phase_o = phase;
        end
    end

endmodule

// File: tb/tb_de_pipeline_ctrl.sv
// Scoreboard bench for de_pipeline_ctrl: driver queues expected output vectors,
// a negedge monitor pops and compares them.
module tb_de_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] d_src1, d_src2, de_reg_dst;
    logic       d_use1, d_use2, de_mr, de_rw;
    logic       ex_br, int_req, mem_busy;
    logic       pc_write, fd_write, fd_flush, de_hold, de_flush, int_ack;
    logic [1:0] flash_num, int_phase;

    always #5 clk = ~clk;

    de_pipeline_ctrl #(.BRANCH_PENALTY(2), .INT_CYCLES(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .d_src1_i(d_src1), .d_src2_i(d_src2), .d_use1_i(d_use1), .d_use2_i(d_use2),
        .de_mr_i(de_mr), .de_rw_i(de_rw), .de_reg_dst_i(de_reg_dst),
        .ex_branch_taken_i(ex_br), .int_req_i(int_req), .mem_busy_i(mem_busy),
        .pc_write_o(pc_write), .fd_write_o(fd_write), .fd_flush_o(fd_flush),
        .de_hold_o(de_hold), .de_flush_o(de_flush), .flash_num_o(flash_num),
        .int_ack_o(int_ack), .int_phase_o(int_phase)
    );

    typedef struct {
        logic [9:0] exp;
        logic [9:0] mask;
        string      name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Bit order: pc_write fd_write fd_flush de_hold de_flush flash_num[1:0] int_ack int_phase[1:0]
    localparam logic [9:0] FULL    = 10'h3FF;
    localparam logic [9:0] NO_FDW  = 10'h2FF;
    localparam logic [9:0] RST_V   = 10'b0_0_1_0_1_00_0_00;
    localparam logic [9:0] RUN_V   = 10'b1_1_0_0_0_00_0_00;
    localparam logic [9:0] LU_V    = 10'b0_0_0_0_1_00_0_00;
    localparam logic [9:0] BR1_V   = 10'b1_0_1_0_1_01_0_00;
    localparam logic [9:0] BR0_V   = 10'b1_0_1_0_1_00_0_00;
    localparam logic [9:0] INT0_V  = 10'b0_0_0_0_1_00_0_00;
    localparam logic [9:0] INTA_V  = 10'b1_0_0_0_1_00_1_01;
    localparam logic [9:0] MEM_V   = 10'b0_0_0_1_0_00_0_00;

    // Queue an expectation for the current cycle, then advance to the next cycle.
    task automatic chk(input logic [9:0] e, input logic [9:0] m, input string nm);
        sb_item_t it;
        it.exp  = e;
        it.mask = m;
        it.name = nm;
        sb_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        d_src1 = 3'd0; d_src2 = 3'd0; de_reg_dst = 3'd0;
        d_use1 = 1'b0; d_use2 = 1'b0; de_mr = 1'b0; de_rw = 1'b0;
        ex_br = 1'b0; int_req = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_hazard(input logic [2:0] s1, input logic u1,
                              input logic [2:0] s2, input logic u2);
        de_mr = 1'b1; de_rw = 1'b1; de_reg_dst = 3'd3;
        d_src1 = s1; d_use1 = u1; d_src2 = s2; d_use2 = u2;
    endtask

    // Monitor: outputs are valid every cycle; compare at negedge, away from posedge.
    initial begin
        sb_item_t it;
        logic [9:0] obs;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                obs = {pc_write, fd_write, fd_flush, de_hold, de_flush,
                       flash_num, int_ack, int_phase};
                n_checks++;
                if ((obs & it.mask) !== (it.exp & it.mask)) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b (mask %b)", it.name, obs, it.exp, it.mask);
                end else begin
                    $display("ok   %s: outputs %b", it.name, obs);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;

        chk(RST_V, FULL, "reset_c0");
        chk(RST_V, FULL, "reset_c1");
        chk(RST_V, FULL, "reset_c2");
        rst_n = 1'b1;
        chk(RUN_V, FULL, "after_reset_run");

        set_hazard(3'd3, 1'b1, 3'd0, 1'b0);
`ifdef LOAD_USE_STALL_EN
        chk(LU_V, FULL, "loaduse_src1_bubble");
        clear_inputs();
        chk(RUN_V, FULL, "loaduse_src1_stall_cycle");
`else
        chk(RUN_V, FULL, "loaduse_src1_ignored");
        clear_inputs();
`endif
        chk(RUN_V, FULL, "loaduse_src1_resume");
        set_hazard(3'd4, 1'b1, 3'd0, 1'b0);
        chk(RUN_V, FULL, "no_hazard_src1_4");
        set_hazard(3'd0, 1'b0, 3'd3, 1'b1);
`ifdef LOAD_USE_STALL_EN
        chk(LU_V, FULL, "loaduse_src2_bubble");
        clear_inputs();
        chk(RUN_V, FULL, "loaduse_src2_stall_cycle");
`else
        chk(RUN_V, FULL, "loaduse_src2_ignored");
        clear_inputs();
`endif
        set_hazard(3'd3, 1'b0, 3'd3, 1'b0);
        chk(RUN_V, FULL, "no_hazard_unused_src");
        clear_inputs();

        ex_br = 1'b1;
        chk(BR1_V, NO_FDW, "branch_flash1");
        ex_br = 1'b0;
        chk(BR0_V, NO_FDW, "branch_flash0");
        chk(RUN_V, FULL, "branch_done");

        ex_br = 1'b1;
        chk(BR1_V, NO_FDW, "branch2_flash1");
        ex_br = 1'b0; int_req = 1'b1;
        chk(BR0_V, NO_FDW, "int_masked_in_flush");
        chk(INT0_V, FULL, "int_detect_run");
        chk(INT0_V, FULL, "int_phase0");
        chk(INTA_V, FULL, "int_phase1_ack");
        int_req = 1'b0;
        chk(RUN_V, FULL, "int_done");

        mem_busy = 1'b1; ex_br = 1'b1; set_hazard(3'd3, 1'b1, 3'd3, 1'b1);
        chk(MEM_V, FULL, "mem_priority_run");
        chk(MEM_V, FULL, "memwait_1");
        chk(MEM_V, FULL, "memwait_2");
        clear_inputs();
        chk(RUN_V, FULL, "memwait_release");
        chk(RUN_V, FULL, "after_memwait");

        int_req = 1'b1;
        chk(INT0_V, FULL, "int2_detect_run");
        chk(INT0_V, FULL, "int2_phase0");
        rst_n = 1'b0; int_req = 1'b0;
        chk(RST_V, FULL, "reset_mid_int");
        rst_n = 1'b1;
        chk(RUN_V, FULL, "run_after_int_reset");
        chk(RUN_V, FULL, "run_after_int_reset2");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
